// File: rtl/timekeeper_core_if.sv
// Time-setting load channel: the setter presents hours/minutes with load_req,
// and the timekeeper answers with a one-cycle load_done.
interface timekeeper_core_if;
   // load_req rising edge = transfer; data must be valid in that cycle; load_done pulses the cycle after
   logic       load_req;
   logic [4:0] i_hours;
   logic [5:0] i_minutes;
   logic       load_done;

   modport master (output load_req, output i_hours, output i_minutes, input load_done);
   modport slave  (input load_req, input i_hours, input i_minutes, output load_done);
endinterface

// File: rtl/timekeeper_core.sv
// 24 h HH:MM:SS time-of-day counter with a 1 Hz prescaler and a load channel.
// Optional 12 h display outputs are enabled with the HOUR12_EN macro.
module timekeeper_core #(
   parameter int TICKS_PER_SEC = 32768
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hold,
   timekeeper_core_if.slave ts,
   output logic [4:0] o_hours,
   output logic [5:0] o_minutes,
   output logic [5:0] o_seconds,
   output logic       sec_tick
`ifdef HOUR12_EN
   ,
   output logic [3:0] o_hours12,
   output logic       o_pm
`endif
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

   logic [PW-1:0] prescaler;
   logic          load_req_q;
   logic          load_edge;
   logic [4:0]    load_hours;
   logic [5:0]    load_minutes;

   assign load_edge    = ts.load_req & ~load_req_q;
   assign load_hours   = (ts.i_hours >= 5'd24) ? ts.i_hours - 5'd24 : ts.i_hours;
   assign load_minutes = (ts.i_minutes >= 6'd60) ? ts.i_minutes - 6'd60 : ts.i_minutes;

   // A load in the same cycle swallows the tick; rst gating keeps it low during reset.
   assign sec_tick = rst & (prescaler == PRE_MAX) & ~hold & ~load_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescaler    <= '0;
         o_hours      <= '0;
         o_minutes    <= '0;
         o_seconds    <= '0;
         load_req_q   <= 1'b0;
         ts.load_done <= 1'b0;
      end else begin
         load_req_q   <= ts.load_req;
         ts.load_done <= load_edge;
         if (load_edge) begin
            o_hours   <= load_hours;
            o_minutes <= load_minutes;
            o_seconds <= '0;
            prescaler <= '0;
         end else if (!hold) begin
            prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + 1'b1;
            if (sec_tick) begin
               if (o_seconds == 6'd59) begin
                  o_seconds <= '0;
                  if (o_minutes == 6'd59) begin
                     o_minutes <= '0;
                     o_hours   <= (o_hours == 5'd23) ? 5'd0 : o_hours + 5'd1;
                  end else begin
                     o_minutes <= o_minutes + 6'd1;
                  end
               end else begin
                  o_seconds <= o_seconds + 6'd1;
               end
            end
         end
      end
   end

`ifdef HOUR12_EN
   logic [4:0] hours_minus12;
   assign hours_minus12 = o_hours - 5'd12;

   always_comb begin
      o_hours12 = 4'd12;
      o_pm      = 1'b0;
      if (o_hours == 5'd0) begin
         o_hours12 = 4'd12;
         o_pm      = 1'b0;
      end else if (o_hours < 5'd12) begin
         o_hours12 = o_hours[3:0];
         o_pm      = 1'b0;
      end else if (o_hours == 5'd12) begin
         o_hours12 = 4'd12;
         o_pm      = 1'b1;
      end else begin
         o_hours12 = hours_minus12[3:0];
         o_pm      = 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_timekeeper_core.sv
// Bench for timekeeper_core with TICKS_PER_SEC=4: directed loads/holds/resets,
// a seconds-of-day reference model checked every negedge, plus literal checks.
module tb_timekeeper_core;
   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       hold;
   logic [4:0] o_hours;
   logic [5:0] o_minutes;
   logic [5:0] o_seconds;
   logic       sec_tick;
`ifdef HOUR12_EN
   logic [3:0] o_hours12;
   logic       o_pm;
`endif

   int checks = 0;
   int errors = 0;

   timekeeper_core_if ts ();

   timekeeper_core #(.TICKS_PER_SEC(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .ts        (ts.slave),
      .o_hours   (o_hours),
      .o_minutes (o_minutes),
      .o_seconds (o_seconds),
      .sec_tick  (sec_tick)
`ifdef HOUR12_EN
      ,
      .o_hours12 (o_hours12),
      .o_pm      (o_pm)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: time = load base + running cycles / T, modulo one day.
   int base_sec = 0;
   int elapsed  = 0;
   bit lq_m     = 1'b0;
   bit done_m   = 1'b0;

   always @(negedge clk) begin
      int tot, eh, em, es, hh, mm;
      bit edge_m, tick_m;
      if (!rst) begin
         base_sec = 0; elapsed = 0; lq_m = 1'b0; done_m = 1'b0;
      end
      tot = (base_sec + elapsed / T) % 86400;
      eh  = tot / 3600;
      em  = (tot / 60) % 60;
      es  = tot % 60;
      edge_m = rst && ts.load_req && !lq_m;
      tick_m = rst && !hold && !edge_m && (elapsed % T == T - 1);
      chk("m_hours", int'(o_hours), eh);
      chk("m_minutes", int'(o_minutes), em);
      chk("m_seconds", int'(o_seconds), es);
      chk("m_sec_tick", int'(sec_tick), int'(tick_m));
      chk("m_load_done", int'(ts.load_done), int'(done_m));
`ifdef HOUR12_EN
      chk("m_hours12", int'(o_hours12), (eh % 12 == 0) ? 12 : eh % 12);
      chk("m_pm", int'(o_pm), (eh >= 12) ? 1 : 0);
`endif
      if (rst) begin
         done_m = edge_m;
         if (edge_m) begin
            hh = (ts.i_hours >= 24) ? int'(ts.i_hours) - 24 : int'(ts.i_hours);
            mm = (ts.i_minutes >= 60) ? int'(ts.i_minutes) - 60 : int'(ts.i_minutes);
            base_sec = hh * 3600 + mm * 60;
            elapsed  = 0;
         end else if (!hold) begin
            elapsed++;
         end
         lq_m = ts.load_req;
      end
   end

   task automatic do_load(input logic [4:0] h, input logic [5:0] m);
      ts.i_hours   = h;
      ts.i_minutes = m;
      ts.load_req  = 1'b1;
      cyc();
      ts.load_req  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int ticks, last_k, done_cnt, snap_s, snap_m, n;
      rst = 1'b0; hold = 1'b0;
      ts.load_req = 1'b0; ts.i_hours = '0; ts.i_minutes = '0;
      repeat (3) cyc();
      chk("rst_hours", int'(o_hours), 0);
      chk("rst_seconds", int'(o_seconds), 0);
      chk("rst_tick", int'(sec_tick), 0);
      chk("rst_done", int'(ts.load_done), 0);
`ifdef HOUR12_EN
      chk("rst_hours12", int'(o_hours12), 12);
      chk("rst_pm", int'(o_pm), 0);
`endif
      rst = 1'b1;

      // 1: free run 240 clocks
      ticks = 0; last_k = -1;
      for (int k = 1; k <= 240; k++) begin
         cyc();
         if (sec_tick) begin
            ticks++;
            if (last_k >= 0) chk("tick_spacing", k - last_k, 4);
            last_k = k;
         end
      end
      chk("t1_ticks", ticks, 60);
      chk("t1_minutes", int'(o_minutes), 1);
      chk("t1_seconds", int'(o_seconds), 0);

      // 2: load 23:59, roll over to midnight
      do_load(5'd23, 6'd59);
      chk("t2_hours", int'(o_hours), 23);
      chk("t2_minutes", int'(o_minutes), 59);
      chk("t2_seconds", int'(o_seconds), 0);
      chk("t2_done", int'(ts.load_done), 1);
      for (int k = 0; k < 240; k++) begin
         cyc();
         if (k == 0) chk("t2_done_width", int'(ts.load_done), 0);
      end
      chk("t2_wrap_h", int'(o_hours), 0);
      chk("t2_wrap_m", int'(o_minutes), 0);
      chk("t2_wrap_s", int'(o_seconds), 0);

      // 3: out-of-range load values fold back
      cyc();
      do_load(5'd27, 6'd62);
      chk("t3_hours", int'(o_hours), 3);
      chk("t3_minutes", int'(o_minutes), 2);
      chk("t3_seconds", int'(o_seconds), 0);
      cyc();
      do_load(5'd31, 6'd63);
      chk("t3_hours_max", int'(o_hours), 7);
      chk("t3_minutes_max", int'(o_minutes), 3);

      // 4: long load_req, then hold
      cyc();
      ts.i_hours = 5'd8; ts.i_minutes = 6'd30; ts.load_req = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 14; k++) begin
         cyc();
         if (k == 9) ts.load_req = 1'b0;
         if (ts.load_done) done_cnt++;
      end
      chk("t4_done_count", done_cnt, 1);
      repeat (6) cyc();
      hold = 1'b1;
      snap_s = int'(o_seconds); snap_m = int'(o_minutes);
      ticks = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (sec_tick) ticks++;
         if (k == 19) chk("t4_hold_sec", int'(o_seconds), snap_s);
      end
      chk("t4_hold_ticks", ticks, 0);
      chk("t4_hold_min", int'(o_minutes), snap_m);
      hold = 1'b0;
      repeat (9) cyc();

`ifdef HOUR12_EN
      // 6: 12 h view
      do_load(5'd0, 6'd15);
      chk("t6_h12_0", int'(o_hours12), 12);
      chk("t6_pm_0", int'(o_pm), 0);
      cyc();
      do_load(5'd12, 6'd0);
      chk("t6_h12_12", int'(o_hours12), 12);
      chk("t6_pm_12", int'(o_pm), 1);
      cyc();
      do_load(5'd13, 6'd0);
      chk("t6_h12_13", int'(o_hours12), 1);
      chk("t6_pm_13", int'(o_pm), 1);
      cyc();
`endif

      // 5: load collides with the tick cycle
      n = 0;
      while (n < 20 && !sec_tick) begin
         cyc();
         n++;
      end
      chk("t5_found_tick", int'(sec_tick), 1);
      ts.i_hours = 5'd10; ts.i_minutes = 6'd20; ts.load_req = 1'b1;
      #1;
      chk("t5_tick_suppressed", int'(sec_tick), 0);
      cyc();
      ts.load_req = 1'b0;
      chk("t5_hours", int'(o_hours), 10);
      chk("t5_minutes", int'(o_minutes), 20);
      chk("t5_seconds", int'(o_seconds), 0);
      repeat (3) cyc();
      chk("t5_sec_before", int'(o_seconds), 0);
      cyc();
      chk("t5_sec_after", int'(o_seconds), 1);

      // reset while load_done is pending, then load on first cycle after release
      do_load(5'd5, 6'd6);
      ts.load_req = 1'b1;
      chk("t5_pre_rst_done", int'(ts.load_done), 1);
      rst = 1'b0;
      #1;
      chk("t5_rst_hours", int'(o_hours), 0);
      chk("t5_rst_minutes", int'(o_minutes), 0);
      chk("t5_rst_done", int'(ts.load_done), 0);
      repeat (2) cyc();
      rst = 1'b1;
      cyc();
      ts.load_req = 1'b0;
      chk("t5_post_rst_hours", int'(o_hours), 5);
      chk("t5_post_rst_done", int'(ts.load_done), 1);
      repeat (4) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
